bp_fe_queue_buffer: RTL and testbench

// - Circular FIFO between FE pc_gen/icache output (fe_queue) and BE issue; decouples fetch from issue stalls.
// - Upstream: FE top fe_queue_o/fe_queue_v_o/fe_queue_ready_i. Downstream: BE scheduler, valid->yumi.
// - BE redirects (fe_cmd) invalidate all buffered fetches via flush_i.

---
 rtl/bp_fe_queue_buffer.sv | 72 +++++++
 tb/tb_bp_fe_queue_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_buffer.sv
// bp_fe_queue_buffer: circular FIFO decoupling FE fetch from BE issue; `define BP_FE_QUEUE_BUFFER_STATS_EN adds hwm_o/flush_drop_o
module bp_fe_queue_buffer #(
  parameter int fe_queue_width_p = 128,
  parameter int els_p = 8,
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [fe_queue_width_p-1:0] fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  output logic [fe_queue_width_p-1:0] fe_queue_o,
  output logic                        fe_queue_v_o,
  input  logic                        fe_queue_yumi_i,
  input  logic                        flush_i,
  output logic [cnt_width_lp-1:0]     count_o
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
  ,output logic [cnt_width_lp-1:0]    hwm_o
  ,output logic [15:0]                flush_drop_o
`endif
);
  localparam logic [ptr_width_lp-1:0] last_ptr = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt = cnt_width_lp'(els_p);
  logic [fe_queue_width_p-1:0] mem [els_p];
  logic [ptr_width_lp-1:0] wptr, rptr;
  logic [cnt_width_lp-1:0] count;
  logic enq, deq;
  // handshakes and head data; head is forced to zero while empty so stale storage never leaks
  always_comb begin
    fe_queue_ready_o = (count != full_cnt) & ~flush_i;
    fe_queue_v_o = count != '0;
    enq = fe_queue_v_i & fe_queue_ready_o;
    deq = fe_queue_yumi_i & fe_queue_v_o & ~flush_i;
    fe_queue_o = fe_queue_v_o ? mem[rptr] : '0;
    count_o = count;
  end
  // pointers and occupancy; flush wins over any enqueue/dequeue in the same cycle
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= (wptr == last_ptr) ? '0 : wptr + 1'b1;
      if (deq) rptr <= (rptr == last_ptr) ? '0 : rptr + 1'b1;
      count <= count + cnt_width_lp'(enq) - cnt_width_lp'(deq);
    end
  // entry storage is deliberately left unreset
  always_ff @(posedge clk_i)
    if (enq) mem[wptr] <= fe_queue_i;
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, flush_drop_o} + 17'(count);
  // high-water mark and saturating count of entries discarded by flushes
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      hwm_o <= '0;
      flush_drop_o <= '0;
    end else begin
      if (count > hwm_o) hwm_o <= count;
      if (flush_i) flush_drop_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i) fe_queue_yumi_i |-> fe_queue_v_o);
  a_count_range: assert property (@(posedge clk_i) disable iff (reset_i) count <= full_cnt);
  a_enq_known: assert property (@(posedge clk_i) disable iff (reset_i) enq |-> !$isunknown(fe_queue_i));
endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// tb_bp_fe_queue_buffer: scoreboard bench with a queue-based reference model for bp_fe_queue_buffer
module tb_bp_fe_queue_buffer;
  localparam int W = 128;
  localparam int N = 8;
  logic clk_i = 0;
  logic reset_i = 1;
  logic [W-1:0] fe_queue_i = '0;
  logic fe_queue_v_i = 0;
  logic fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic fe_queue_v_o;
  logic fe_queue_yumi_i = 0;
  logic flush_i = 0;
  logic [3:0] count_o;
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
  logic [3:0] hwm_o;
  logic [15:0] flush_drop_o;
`endif
  int checks = 0;
  int errors = 0;
  logic [W-1:0] model[$];
  logic [W-1:0] exp_q[$];
  int hwm_m = 0;
  int drop_m = 0;

  bp_fe_queue_buffer #(.fe_queue_width_p(W), .els_p(N)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .fe_queue_i(fe_queue_i),
    .fe_queue_v_i(fe_queue_v_i),
    .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o),
    .fe_queue_v_o(fe_queue_v_o),
    .fe_queue_yumi_i(fe_queue_yumi_i),
    .flush_i(flush_i),
    .count_o(count_o)
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
    ,.hwm_o(hwm_o)
    ,.flush_drop_o(flush_drop_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // apply the inputs that were held during the cycle that just ended to the model
  task automatic commit();
    bit enq;
    if (model.size() > hwm_m) hwm_m = model.size();
    if (flush_i) begin
      drop_m = (drop_m + model.size() > 16'hFFFF) ? 16'hFFFF : drop_m + model.size();
      model.delete();
    end else begin
      enq = fe_queue_v_i && model.size() < N;
      if (fe_queue_yumi_i) void'(model.pop_front());
      if (enq) model.push_back(fe_queue_i);
    end
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit f);
    @(posedge clk_i);
    #1;
    commit();
    fe_queue_v_i = v;
    fe_queue_i = d;
    fe_queue_yumi_i = y && model.size() > 0;
    flush_i = f;
    if (fe_queue_yumi_i) exp_q.push_back(model[0]);
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // monitor: compare occupancy/handshakes every cycle and pop expected heads on each consume
  always @(negedge clk_i) begin
    if (!reset_i) begin
      chk("count", W'(count_o), W'(model.size()));
      chk("valid", W'(fe_queue_v_o), W'(model.size() != 0));
      chk("ready", W'(fe_queue_ready_o), W'(model.size() != N && !flush_i));
      if (!fe_queue_v_o) chk("head_idle", fe_queue_o, '0);
      if (fe_queue_yumi_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: consume with no expected entry, got %0h", fe_queue_o);
        end else chk("head", fe_queue_o, exp_q.pop_front());
      end
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
      chk("hwm", W'(hwm_o), W'(hwm_m));
      chk("flush_drop", W'(flush_drop_o), W'(drop_m));
`endif
    end
  end

  initial begin
    #2;
    chk("rst_valid", W'(fe_queue_v_o), '0);
    chk("rst_ready", W'(fe_queue_ready_o), W'(1));
    chk("rst_count", W'(count_o), '0);
    chk("rst_head", fe_queue_o, '0);
    #20 reset_i = 0;
    for (int i = 0; i < 9; i++) step(1, W'(8'hA1 + i), 0, 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0);
    for (int i = 0; i < 20; i++) step(1, rnd(), 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, rnd(), 0, 0);
    step(1, W'(8'hBB), 1, 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 1);
    step(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rnd(), 1, 1);
    step(0, '0, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(9, 0) < 7, rnd(), $urandom_range(1, 0) == 1, $urandom_range(29, 0) == 0);
    step(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0);
    step(0, '0, 0, 0);
    @(posedge clk_i);
    #3 reset_i = 1;
    #1;
    chk("arst_valid", W'(fe_queue_v_o), '0);
    chk("arst_count", W'(count_o), '0);
    chk("arst_head", fe_queue_o, '0);
`ifdef BP_FE_QUEUE_BUFFER_STATS_EN
    chk("arst_hwm", W'(hwm_o), '0);
`endif
    model.delete();
    exp_q.delete();
    hwm_m = 0;
    drop_m = 0;
    @(negedge clk_i);
    #1 reset_i = 0;
    for (int i = 0; i < 200; i++)
      step($urandom_range(1, 0) == 1, rnd(), $urandom_range(1, 0) == 1, $urandom_range(19, 0) == 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
